// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//   Sequential restoring (shift-subtract) unsigned divider. It produces one
//   quotient bit per clock. A start/end_op handshake frames each operation,
//   and a zero divisor is flagged instead of being iterated.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | N shift-subtract iterations; busy=1; outputs still hold
//   DONE  | one cycle with end_op=1; start here begins the next operation
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   start        request, sampled in IDLE or DONE
//   dividend     numerator, captured with start
//   divisor      denominator, captured with start
//   quotient     result quotient (all ones when dividing by zero)
//   remainder    result remainder (the dividend when dividing by zero)
//   busy         high while iterating
//   end_op       one-cycle pulse when the results are valid
//   div_by_zero  set with end_op if the captured divisor was 0; held
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         end_op,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N:0]      a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            busy_q, busy_d;
    logic            end_op_q, end_op_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      a_sh;
    logic [N:0]      diff;

    // After every restore the partial remainder is below the divisor. This
    // means the sign bit of the held A is always 0, so the shift never reads it.
    logic            unused_a_sign;
    assign unused_a_sign = a_q[N];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        end_op_d    = 1'b0;
        dbz_d       = dbz_q;

        a_sh = {a_q[N-1:0], q_q[N-1]};
        diff = a_sh - {1'b0, b_q};

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        end_op_d    = 1'b1;
                        state_d     = DONE;
                    end else begin
                        a_d     = '0;
                        q_d     = dividend;
                        b_d     = divisor;
                        cnt_d   = CW'(N);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - CW'(1);
                // A non-negative difference means the divisor fits, so we keep
                // it. Otherwise we restore the shifted value.
                if (!diff[N]) begin
                    a_d = diff;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    a_d = a_sh;
                    q_d = {q_q[N-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    quotient_d  = q_d;
                    remainder_d = a_d[N-1:0];
                    dbz_d       = 1'b0;
                    end_op_d    = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            end_op_q    <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            end_op_q    <= end_op_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign end_op      = end_op_q;
    assign div_by_zero = dbz_q;

endmodule
